// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port types for the instruction/data arbiter.
// Compile with ROUND_ROBIN_EN defined to select round-robin conflict resolution.
package mem_arbiter_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IMEM = 2'd1,
        DMEM = 2'd2
    } arb_owner_type;

    localparam mem_in_type  MEM_IN_NONE  = '0;
    localparam mem_out_type MEM_OUT_NONE = '0;

    // Conflict-free selection; 'both_pick' resolves the case where both ports want the bus.
    function automatic arb_owner_type arb_pick(input logic i_req, input logic d_req,
                                               input arb_owner_type both_pick);
        if (i_req && d_req) return both_pick;
        if (i_req)          return IMEM;
        if (d_req)          return DMEM;
        return IDLE;
    endfunction

endpackage

// File: rtl/mem_arbiter_pending_slot.sv
// One-entry request holder: presents the incoming pulse if present, else the held request.
module arb_pending_slot
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  mem_in_type req,
    input  logic       grant,
    output mem_in_type cand
);

    mem_in_type pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= MEM_IN_NONE;
        end else if (grant) begin
            pend_q <= MEM_IN_NONE;
        end else if (req.mem_valid) begin
            pend_q <= req;
        end
    end

    assign cand = req.mem_valid ? req : pend_q;

    // A second pulse while one is still held breaks the one-outstanding upstream contract.
    assert property (@(posedge clk) disable iff (rst) !(req.mem_valid && pend_q.mem_valid))
        else $error("arb_pending_slot: request overwrote a pending request");

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one instruction/data arbiter onto a single memory port, one transaction in flight.
// ROUND_ROBIN_EN selects round-robin conflict resolution instead of fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit instr_first = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    arb_owner_type owner;
    arb_owner_type winner;
    arb_owner_type both_pick;
    mem_in_type    i_cand;
    mem_in_type    d_cand;
    logic          grant_en;
    logic          gnt_i;
    logic          gnt_d;

`ifdef ROUND_ROBIN_EN
    arb_owner_type rr_last;

    assign both_pick = (rr_last == IMEM) ? DMEM : IMEM;
`else
    assign both_pick = instr_first ? IMEM : DMEM;
`endif

    arb_pending_slot u_islot (
        .clk   (clk),
        .rst   (rst),
        .req   (imem_in),
        .grant (gnt_i),
        .cand  (i_cand)
    );

    arb_pending_slot u_dslot (
        .clk   (clk),
        .rst   (rst),
        .req   (dmem_in),
        .grant (gnt_d),
        .cand  (d_cand)
    );

    // The owner is released in its mem_ready cycle, so the next grant happens with no bubble.
    assign grant_en = !rst && ((owner == IDLE) || mem_out.mem_ready);
    assign winner   = arb_pick(i_cand.mem_valid, d_cand.mem_valid, both_pick);
    assign gnt_i    = grant_en && (winner == IMEM);
    assign gnt_d    = grant_en && (winner == DMEM);

    always_comb begin
        mem_in = MEM_IN_NONE;
        if (gnt_i) begin
            mem_in           = i_cand;
            mem_in.mem_instr = 1'b1;
        end else if (gnt_d) begin
            mem_in           = d_cand;
            mem_in.mem_instr = 1'b0;
        end
    end

    // Responses only reach the current owner; anything arriving while idle or in reset is dropped.
    always_comb begin
        imem_out = MEM_OUT_NONE;
        dmem_out = MEM_OUT_NONE;
        if (!rst) begin
            if (owner == IMEM) imem_out = mem_out;
            if (owner == DMEM) dmem_out = mem_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= IDLE;
`ifdef ROUND_ROBIN_EN
            rr_last <= DMEM;
`endif
        end else if (grant_en) begin
            owner <= winner;
`ifdef ROUND_ROBIN_EN
            if (winner != IDLE) rr_last <= winner;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus a back-to-back conflict run.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    mem_in_type  imem_in, dmem_in, mem_in;
    mem_out_type imem_out, dmem_out, mem_out;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.instr_first(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] iaddr;
        logic        dv;
        logic        df;
        logic [31:0] daddr;
        logic [3:0]  dws;
        logic        mr;
        logic [31:0] mrd;
        mem_in_type  e_mem;
        mem_out_type e_i;
        mem_out_type e_d;
    } vec_t;

    // eg: 0 = nothing issued, 1 = imem issued, 2 = dmem issued
    function automatic vec_t row(input logic r, input logic iv, input logic [31:0] iaddr,
                                 input logic dv, input logic df, input logic [31:0] daddr,
                                 input logic [3:0] dws, input logic mr, input logic [31:0] mrd,
                                 input int eg, input logic [31:0] eaddr, input logic ef,
                                 input logic [3:0] ews, input logic eir, input logic edr);
        vec_t v;
        v.rst = r;   v.iv = iv; v.iaddr = iaddr;
        v.dv = dv;   v.df = df; v.daddr = daddr; v.dws = dws;
        v.mr = mr;   v.mrd = mrd;
        v.e_mem = '0;
        if (eg != 0) begin
            v.e_mem.mem_valid = 1'b1;
            v.e_mem.mem_fence = ef;
            v.e_mem.mem_instr = (eg == 1);
            v.e_mem.mem_addr  = eaddr;
            v.e_mem.mem_wdata = (eg == 2) ? {16'hD0D0, eaddr[15:0]} : 32'h0;
            v.e_mem.mem_wstrb = ews;
        end
        v.e_i.mem_ready = eir;
        v.e_i.mem_rdata = eir ? mrd : 32'h0;
        v.e_d.mem_ready = edr;
        v.e_d.mem_rdata = edr ? mrd : 32'h0;
        return v;
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [31:0] iaddr,
                         input logic dv, input logic df, input logic [31:0] daddr,
                         input logic [3:0] dws, input logic mr, input logic [31:0] mrd);
        rst     = r;
        imem_in = '0;
        imem_in.mem_valid = iv;
        imem_in.mem_addr  = iaddr;
        dmem_in = '0;
        dmem_in.mem_valid = dv;
        dmem_in.mem_fence = df;
        dmem_in.mem_instr = 1'b1;  // must be overridden to 0 on issue
        dmem_in.mem_addr  = daddr;
        dmem_in.mem_wdata = {16'hD0D0, daddr[15:0]};
        dmem_in.mem_wstrb = dws;
        mem_out.mem_ready = mr;
        mem_out.mem_rdata = mr ? mrd : 32'h0;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [3:0] exp_g;  // bit k = mem_instr of grant k in the conflict run
    logic       prev;
    logic       rr_mode;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        //           rst iv iaddr      dv df daddr      dws  mr mrd           eg eaddr      ef ews  ir dr
        vecs.push_back(row(1, 0, 0,         0, 0, 0,         4'h0, 0, 0,            0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(1, 0, 0,         0, 0, 0,         4'h0, 1, 32'h99,       0, 0,         0, 4'h0, 0, 0));
        // single dmem request, ready two cycles later
        vecs.push_back(row(0, 0, 0,         1, 0, 32'h100,   4'hF, 0, 0,            2, 32'h100,   0, 4'hF, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 0, 0,            0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h11,       0, 0,         0, 4'h0, 0, 1));
        // single imem request
        vecs.push_back(row(0, 1, 32'h80,    0, 0, 0,         4'h0, 0, 0,            1, 32'h80,    0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h66,       0, 0,         0, 4'h0, 1, 0));
        // simultaneous pulses: dmem first, imem in dmem's ready cycle
        vecs.push_back(row(0, 1, 32'h0,     1, 0, 32'h200,   4'hF, 0, 0,            2, 32'h200,   0, 4'hF, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 0, 0,            0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h22,       1, 32'h0,     0, 4'h0, 0, 1));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h33,       0, 0,         0, 4'h0, 1, 0));
        // dmem fence, imem queued behind it
        vecs.push_back(row(0, 0, 0,         1, 1, 32'h300,   4'h0, 0, 0,            2, 32'h300,   1, 4'h0, 0, 0));
        vecs.push_back(row(0, 1, 32'h40,    0, 0, 0,         4'h0, 0, 0,            0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 0, 0,            0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h0,        1, 32'h40,    0, 4'h0, 0, 1));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h44,       0, 0,         0, 4'h0, 1, 0));
        // owner ready plus a new pulse from the same port
        vecs.push_back(row(0, 0, 0,         1, 0, 32'h500,   4'h3, 0, 0,            2, 32'h500,   0, 4'h3, 0, 0));
        vecs.push_back(row(0, 0, 0,         1, 0, 32'h504,   4'hC, 1, 32'hDEADBEEF, 2, 32'h504,   0, 4'hC, 0, 1));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h55,       0, 0,         0, 4'h0, 0, 1));
        // reset mid-transaction, stale ready afterwards
        vecs.push_back(row(0, 0, 0,         1, 0, 32'h600,   4'hF, 0, 0,            2, 32'h600,   0, 4'hF, 0, 0));
        vecs.push_back(row(1, 0, 0,         0, 0, 0,         4'h0, 0, 0,            0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h77,       0, 0,         0, 4'h0, 0, 0));
        vecs.push_back(row(0, 0, 0,         1, 0, 32'h700,   4'hF, 0, 0,            2, 32'h700,   0, 4'hF, 0, 0));
        vecs.push_back(row(0, 0, 0,         0, 0, 0,         4'h0, 1, 32'h88,       0, 0,         0, 4'h0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].iaddr, vecs[i].dv, vecs[i].df,
                  vecs[i].daddr, vecs[i].dws, vecs[i].mr, vecs[i].mrd);
            #2;
            check($sformatf("vec%0d", i), {23'h0, mem_in, imem_out, dmem_out},
                  {23'h0, vecs[i].e_mem, vecs[i].e_i, vecs[i].e_d});
            tick();
        end

        // Back-to-back conflicts: the port whose response completes re-requests immediately.
`ifdef ROUND_ROBIN_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        exp_g = rr_mode ? 4'b1010 : 4'b0000;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 32'h2000, 4'hF, 0, 0);
        #2;
        check("b2b_first", {158'h0, mem_in.mem_valid, mem_in.mem_instr}, {158'h0, 2'b10});
        tick();
        drive(0, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
        #2;
        check("b2b_queue", {159'h0, mem_in.mem_valid}, 160'h0);
        tick();
        for (int k = 1; k < 4; k++) begin
            prev = exp_g[k-1];
            drive(0, prev, 32'h1000 + k, !prev, 0, 32'h2000 + k, 4'hF, 1, 32'h100 + k);
            #2;
            check($sformatf("b2b_grant%0d", k), {158'h0, mem_in.mem_valid, mem_in.mem_instr},
                  {158'h0, 1'b1, exp_g[k]});
            check($sformatf("b2b_resp%0d", k), {158'h0, imem_out.mem_ready, dmem_out.mem_ready},
                  {158'h0, prev, !prev});
            tick();
        end
        prev = exp_g[3];
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h200);
        #2;
        check("b2b_drain", {158'h0, mem_in.mem_valid, mem_in.mem_instr}, {158'h0, 1'b1, !prev});
        check("b2b_drain_resp", {158'h0, imem_out.mem_ready, dmem_out.mem_ready},
              {158'h0, prev, !prev});
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h201);
        #2;
        check("b2b_last", {157'h0, mem_in.mem_valid, imem_out.mem_ready, dmem_out.mem_ready},
              {157'h0, 1'b0, !prev, prev});
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("b2b_idle", {23'h0, mem_in, imem_out, dmem_out}, 160'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
